gfx_mem_arbiter: RTL and testbench
==================================

Name: gfx_mem_arbiter

Overview:
- Shares one memory command port between the display read stream and the gfx pixel write stream in the striped gfx/VGA framebuffer.
- Display reads get priority while the display pixel fifo is low, so the screen never underflows.
- Otherwise the two streams share the port through a bounded-burst scheme.
- Sits between the display address generator and gfx front end (upstream) and the striped SRAM AXI-style command path (downstream).

Parameters:
- ADDR_WIDTH, 10, memory word address width
- DATA_WIDTH, 16, memory data width
- LEVEL_BITS, 5, width of the fifo_level input
- LOW_WATER, 8, display is urgent while fifo_level < LOW_WATER
- MAX_RD_BURST, 4, maximum consecutive non-urgent display grants while gfx is waiting

Ports:
- clk  in  1  system/AXI clock
- reset  in  1  synchronous, active-high
- fifo_level  in  LEVEL_BITS  display pixel fifo write-side occupancy
- disp_addr  in  ADDR_WIDTH  display read address
- disp_valid  in  1  display read request valid
- disp_ready  out  1  display request accepted this cycle
- gfx_addr  in  ADDR_WIDTH  gfx write address
- gfx_data  in  DATA_WIDTH  gfx write data
- gfx_valid  in  1  gfx write request valid
- gfx_ready  out  1  gfx request accepted this cycle
- mem_addr  out  ADDR_WIDTH  command address
- mem_wdata  out  DATA_WIDTH  write data; 0 for reads
- mem_we  out  1  1 = write (gfx), 0 = read (display)
- mem_valid  out  1  command valid
- mem_ready  in  1  downstream accepts command
- urgent  out  1  registered (fifo_level < LOW_WATER)
- rd_burst  out  $clog2(MAX_RD_BURST+1)  consecutive display-grant count

Behaviour:
- Reset values: mem_valid=0, mem_addr=0, mem_wdata=0, mem_we=0, urgent=0, rd_burst=0, last-grant=gfx. disp_ready and gfx_ready are 0 during reset.
- Output stage: single registered command slot, free = !mem_valid || mem_ready. Once mem_valid=1, mem_addr, mem_wdata and mem_we hold stable until mem_ready=1.
- Handshake: disp_ready and gfx_ready are combinational.
  - Both are 0 when the slot is not free.
  - At most one is 1 in any cycle.
  - A transfer occurs on valid && ready. The accepted request is loaded into the slot next cycle (1-cycle latency to mem_valid).
  - Back-to-back acceptance is allowed when mem_ready=1.
- urgent is registered from fifo_level each cycle. Arbitration uses the registered value, so a fifo_level change takes effect 1 cycle later.
- Arbitration, evaluated when the slot is free; states are GRANT_DISP and GRANT_GFX, tracked by the last-grant flop:
  - Only one requester valid: it wins.
  - urgent=1 and disp_valid: display wins regardless of rd_burst. gfx stalls.
  - urgent=0 and both valid: display wins if rd_burst < MAX_RD_BURST, else gfx wins.
  - Neither valid: slot drains, and mem_valid drops after mem_ready.
- rd_burst counter:
  - Increments on each display grant, saturating at MAX_RD_BURST.
  - Clears to 0 on any gfx grant.
  - Also clears when gfx_valid=0 and the slot is free with no grant (idle).
- Slot contents on grant:
  - Gfx grant: mem_we=1, mem_wdata=gfx_data.
  - Display grant: mem_we=0, mem_wdata=0.
- A request with valid high and ready low must not be dropped. Requesters hold their request; the arbiter holds no request state.
- Reset mid-operation: an in-flight slot command is discarded and mem_valid returns to 0 the next cycle. No partial transfers.
- fifo_level at its maximum (all ones) is legal and never urgent unless LOW_WATER exceeds it.

Test Plan:
- Idle: disp_valid=0, gfx_valid=0 for 20 cycles -> mem_valid=0 throughout, rd_burst=0.
- Display only: fifo_level=20, disp_valid=1 with addr 0..15, mem_ready=1 -> 16 consecutive reads, mem_we=0, addr 0..15 in order, one per cycle after 1-cycle latency.
- Non-urgent contention: fifo_level=20, both valid continuously -> repeating grant pattern of 4 display then 1 gfx. rd_burst sequence is 1,2,3,4,0.
- Urgent: fifo_level=3, both valid -> display granted every cycle, gfx_ready=0. Raise fifo_level to 20 -> first gfx grant follows within 2 cycles (rd_burst already saturated at 4).
- Backpressure: mem_ready held 0 for 5 cycles with a gfx write (addr 0x2A, data 0x123) in the slot -> mem_addr/mem_wdata/mem_we stable, both readys 0. The write is accepted exactly once when mem_ready=1.
- Reset mid-burst: assert reset while mem_valid=1 -> next cycle mem_valid=0 and rd_burst=0. After release, the arbiter resumes granting display first when only disp_valid is asserted.

Source files
------------

// File: rtl/gfx_mem_arbiter.sv
// ============================================================================
// gfx_mem_arbiter : shares one memory command slot between display reads and
//                   gfx writes; display is urgent below the fifo low-water mark
// Revision 1.0    : initial release
// ============================================================================
`default_nettype none

module gfx_mem_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 16,
  parameter int LEVEL_BITS   = 5,
  parameter int LOW_WATER    = 8,
  parameter int MAX_RD_BURST = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [LEVEL_BITS-1:0]             fifo_level,
  input  logic [ADDR_WIDTH-1:0]             disp_addr,
  input  logic                              disp_valid,
  output logic                              disp_ready,
  input  logic [ADDR_WIDTH-1:0]             gfx_addr,
  input  logic [DATA_WIDTH-1:0]             gfx_data,
  input  logic                              gfx_valid,
  output logic                              gfx_ready,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  output logic                              mem_we,
  output logic                              mem_valid,
  input  logic                              mem_ready,
  output logic                              urgent,
  output logic [$clog2(MAX_RD_BURST+1)-1:0] rd_burst
);

  localparam int RB_W = $clog2(MAX_RD_BURST + 1);
  localparam logic [RB_W-1:0] MAX_RB = RB_W'(MAX_RD_BURST);

  typedef enum logic [0:0] {
    GRANT_DISP = 1'b0,
    GRANT_GFX  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  urgent_q, urgent_d;
  logic [RB_W-1:0]       rd_burst_q, rd_burst_d;

  logic slot_free;
  logic grant_disp;
  logic grant_gfx;

  assign slot_free = !mem_valid_q || mem_ready;

  // Arbitration: display wins when alone, when urgent, or while its burst
  // budget lasts; otherwise a waiting gfx write takes the slot.
  always_comb begin
    state_d    = state_q;
    grant_disp = 1'b0;
    grant_gfx  = 1'b0;
    if (!reset && slot_free) begin
      if (disp_valid && (!gfx_valid || urgent_q || (rd_burst_q < MAX_RB))) begin
        grant_disp = 1'b1;
      end else if (gfx_valid) begin
        grant_gfx = 1'b1;
      end
    end
    if (grant_disp) begin
      state_d = GRANT_DISP;
    end else if (grant_gfx) begin
      state_d = GRANT_GFX;
    end
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_valid_d = mem_valid_q;
    rd_burst_d  = rd_burst_q;
    urgent_d    = (32'(fifo_level) < 32'(LOW_WATER));

    if (grant_disp) begin
      mem_addr_d  = disp_addr;
      mem_wdata_d = '0;
      mem_we_d    = 1'b0;
      mem_valid_d = 1'b1;
      rd_burst_d  = (rd_burst_q == MAX_RB) ? MAX_RB : rd_burst_q + RB_W'(1);
    end else if (grant_gfx) begin
      mem_addr_d  = gfx_addr;
      mem_wdata_d = gfx_data;
      mem_we_d    = 1'b1;
      mem_valid_d = 1'b1;
      rd_burst_d  = '0;
    end else if (slot_free) begin
      mem_valid_d = 1'b0;
      if (!gfx_valid) begin
        rd_burst_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= GRANT_GFX;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      urgent_q    <= 1'b0;
      rd_burst_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_valid_q <= mem_valid_d;
      urgent_q    <= urgent_d;
      rd_burst_q  <= rd_burst_d;
    end
  end

  assign disp_ready = grant_disp;
  assign gfx_ready  = grant_gfx;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_valid  = mem_valid_q;
  assign urgent     = urgent_q;
  assign rd_burst   = rd_burst_q;

endmodule

`default_nettype wire

// File: tb/tb_gfx_mem_arbiter.sv
// ============================================================================
// tb_gfx_mem_arbiter : directed vector table plus multi-cycle sequences
// Revision 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_gfx_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LB = 5;
  localparam int RW = 3;

  logic          clk;
  logic          reset;
  logic [LB-1:0] fifo_level;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic          disp_ready;
  logic [AW-1:0] gfx_addr;
  logic [DW-1:0] gfx_data;
  logic          gfx_valid;
  logic          gfx_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_valid;
  logic          mem_ready;
  logic          urgent;
  logic [RW-1:0] rd_burst;

  int checks = 0;
  int errors = 0;

  gfx_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEVEL_BITS(LB),
    .LOW_WATER(8), .MAX_RD_BURST(4)
  ) dut (
    .clk(clk), .reset(reset), .fifo_level(fifo_level),
    .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .gfx_addr(gfx_addr), .gfx_data(gfx_data), .gfx_valid(gfx_valid),
    .gfx_ready(gfx_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .urgent(urgent), .rd_burst(rd_burst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [LB-1:0] lvl;
    logic          dv;
    logic [AW-1:0] da;
    logic          gv;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    logic          mr;
    logic          e_dr;
    logic          e_gr;
    logic          e_mv;
    logic          chk_data;
    logic [AW-1:0] e_ma;
    logic [DW-1:0] e_wd;
    logic          e_we;
    logic          e_urg;
    logic [RW-1:0] e_rb;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [LB-1:0] lvl,
                       input logic dv, input logic [AW-1:0] da,
                       input logic gv, input logic [AW-1:0] ga,
                       input logic [DW-1:0] gd, input logic mr);
    reset = rst; fifo_level = lvl; disp_valid = dv; disp_addr = da;
    gfx_valid = gv; gfx_addr = ga; gfx_data = gd; mem_ready = mr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 5'd20, 1'b0, '0, 1'b0, '0, '0, 1'b1);
    cyc();
  endtask

  initial begin
    //            rst lvl dv da      gv ga      gd        mr  dr gr  mv cd ma      wd        we urg rb
    vecs[0]  = '{1, 20, 1, 10'h000, 0, 10'h000, 16'h0000, 1,  0, 0,  0, 1, 10'h000, 16'h0000, 0, 0, 0};
    vecs[1]  = '{1,  3, 1, 10'h000, 1, 10'h000, 16'h0000, 1,  0, 0,  0, 1, 10'h000, 16'h0000, 0, 0, 0};
    vecs[2]  = '{0, 20, 0, 10'h000, 0, 10'h000, 16'h0000, 1,  0, 0,  0, 0, 10'h000, 16'h0000, 0, 0, 0};
    vecs[3]  = '{0, 20, 1, 10'h005, 0, 10'h000, 16'h0000, 1,  1, 0,  1, 1, 10'h005, 16'h0000, 0, 0, 1};
    vecs[4]  = '{0, 20, 1, 10'h006, 1, 10'h02A, 16'h0123, 1,  1, 0,  1, 1, 10'h006, 16'h0000, 0, 0, 2};
    vecs[5]  = '{0, 20, 1, 10'h007, 1, 10'h02A, 16'h0123, 1,  1, 0,  1, 1, 10'h007, 16'h0000, 0, 0, 3};
    vecs[6]  = '{0, 20, 1, 10'h008, 1, 10'h02A, 16'h0123, 1,  1, 0,  1, 1, 10'h008, 16'h0000, 0, 0, 4};
    vecs[7]  = '{0, 20, 1, 10'h009, 1, 10'h02A, 16'h0123, 1,  0, 1,  1, 1, 10'h02A, 16'h0123, 1, 0, 0};
    vecs[8]  = '{0, 20, 1, 10'h009, 1, 10'h02B, 16'h0456, 0,  0, 0,  1, 1, 10'h02A, 16'h0123, 1, 0, 0};
    vecs[9]  = '{0,  3, 0, 10'h000, 0, 10'h000, 16'h0000, 1,  0, 0,  0, 0, 10'h000, 16'h0000, 0, 1, 0};
    vecs[10] = '{0,  3, 1, 10'h010, 1, 10'h030, 16'h0777, 1,  1, 0,  1, 1, 10'h010, 16'h0000, 0, 1, 1};
    vecs[11] = '{0, 20, 1, 10'h011, 1, 10'h030, 16'h0777, 1,  1, 0,  1, 1, 10'h011, 16'h0000, 0, 0, 2};
    vecs[12] = '{0, 20, 1, 10'h012, 1, 10'h030, 16'h0777, 1,  1, 0,  1, 1, 10'h012, 16'h0000, 0, 0, 3};
    vecs[13] = '{0, 20, 1, 10'h013, 1, 10'h030, 16'h0777, 0,  0, 0,  1, 1, 10'h012, 16'h0000, 0, 0, 3};
    vecs[14] = '{1, 20, 1, 10'h013, 1, 10'h030, 16'h0777, 0,  0, 0,  0, 1, 10'h000, 16'h0000, 0, 0, 0};
    vecs[15] = '{0, 20, 1, 10'h020, 0, 10'h000, 16'h0000, 1,  1, 0,  1, 1, 10'h020, 16'h0000, 0, 0, 1};
    vecs[16] = '{0, 31, 0, 10'h000, 1, 10'h3FF, 16'hFFFF, 1,  0, 1,  1, 1, 10'h3FF, 16'hFFFF, 1, 0, 0};
    vecs[17] = '{0, 31, 0, 10'h000, 0, 10'h000, 16'h0000, 1,  0, 0,  0, 0, 10'h000, 16'h0000, 0, 0, 0};

    drive(1'b1, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].lvl, vecs[i].dv, vecs[i].da,
            vecs[i].gv, vecs[i].ga, vecs[i].gd, vecs[i].mr);
      #1;
      chk($sformatf("v%0d disp_ready", i), int'(disp_ready), int'(vecs[i].e_dr));
      chk($sformatf("v%0d gfx_ready", i), int'(gfx_ready), int'(vecs[i].e_gr));
      cyc();
      chk($sformatf("v%0d mem_valid", i), int'(mem_valid), int'(vecs[i].e_mv));
      chk($sformatf("v%0d urgent", i), int'(urgent), int'(vecs[i].e_urg));
      chk($sformatf("v%0d rd_burst", i), int'(rd_burst), int'(vecs[i].e_rb));
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d mem_addr", i), int'(mem_addr), int'(vecs[i].e_ma));
        chk($sformatf("v%0d mem_wdata", i), int'(mem_wdata), int'(vecs[i].e_wd));
        chk($sformatf("v%0d mem_we", i), int'(mem_we), int'(vecs[i].e_we));
      end
    end

    // Idle for 20 cycles
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 5'd20, 1'b0, '0, 1'b0, '0, '0, 1'b1);
      cyc();
      chk("idle mem_valid", int'(mem_valid), 0);
      chk("idle rd_burst", int'(rd_burst), 0);
    end

    // Display-only stream, one read per cycle
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 5'd20, 1'b1, AW'(k), 1'b0, '0, '0, 1'b1);
      #1;
      chk("disp_only ready", int'(disp_ready), 1);
      cyc();
      chk("disp_only mem_valid", int'(mem_valid), 1);
      chk("disp_only mem_addr", int'(mem_addr), k);
      chk("disp_only mem_we", int'(mem_we), 0);
    end

    // Non-urgent contention: 4 display grants then 1 gfx grant
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(1'b0, 5'd20, 1'b1, 10'h100, 1'b1, 10'h200, 16'hBEEF, 1'b1);
      #1;
      chk("contend disp_ready", int'(disp_ready), (k % 5 < 4) ? 1 : 0);
      chk("contend gfx_ready", int'(gfx_ready), (k % 5 < 4) ? 0 : 1);
      cyc();
      chk("contend rd_burst", int'(rd_burst), (k % 5 < 4) ? (k % 5) + 1 : 0);
      chk("contend mem_we", int'(mem_we), (k % 5 < 4) ? 0 : 1);
    end

    // Urgent: display every cycle, then gfx once fifo refills
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 5'd3, 1'b1, 10'h050, 1'b1, 10'h060, 16'h0AAA, 1'b1);
      #1;
      chk("urgent disp_ready", int'(disp_ready), 1);
      chk("urgent gfx_ready", int'(gfx_ready), 0);
      cyc();
    end
    chk("urgent rd_burst sat", int'(rd_burst), 4);
    drive(1'b0, 5'd20, 1'b1, 10'h050, 1'b1, 10'h060, 16'h0AAA, 1'b1);
    #1;
    chk("refill cyc1 disp_ready", int'(disp_ready), 1);
    cyc();
    #1;
    chk("refill cyc2 gfx_ready", int'(gfx_ready), 1);
    cyc();
    chk("refill gfx mem_we", int'(mem_we), 1);
    chk("refill rd_burst", int'(rd_burst), 0);

    // Backpressure on a gfx write sitting in the slot
    do_reset();
    drive(1'b0, 5'd20, 1'b0, '0, 1'b1, 10'h02A, 16'h0123, 1'b1);
    #1;
    chk("bp accept gfx_ready", int'(gfx_ready), 1);
    cyc();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 5'd20, 1'b1, 10'h077, 1'b1, 10'h099, 16'h0999, 1'b0);
      #1;
      chk("bp disp_ready", int'(disp_ready), 0);
      chk("bp gfx_ready", int'(gfx_ready), 0);
      cyc();
      chk("bp mem_valid", int'(mem_valid), 1);
      chk("bp mem_addr", int'(mem_addr), 'h2A);
      chk("bp mem_wdata", int'(mem_wdata), 'h123);
      chk("bp mem_we", int'(mem_we), 1);
    end
    drive(1'b0, 5'd20, 1'b0, '0, 1'b0, '0, '0, 1'b1);
    cyc();
    chk("bp drained", int'(mem_valid), 0);
    cyc();
    chk("bp once", int'(mem_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
